// File: rtl/mem_req_tracker_if.sv
// Handshake bundle between the processor memory port, the tracker and the memory.
// master drives the processor request/response-ready and memory response side; slave is the tracker.
interface mem_req_tracker_if #(
    parameter int p_req_nbits  = 77,
    parameter int p_resp_nbits = 47
);
    logic [p_req_nbits-1:0]  proc_req_msg;
    logic                    proc_req_val;
    logic                    proc_req_rdy;
    logic [p_req_nbits-1:0]  mem_req_msg;
    logic                    mem_req_val;
    logic                    mem_req_rdy;
    logic [p_resp_nbits-1:0] mem_resp_msg;
    logic                    mem_resp_val;
    logic                    mem_resp_rdy;
    logic [p_resp_nbits-1:0] proc_resp_msg;
    logic                    proc_resp_val;
    logic                    proc_resp_rdy;

    modport master (
        output proc_req_msg, proc_req_val, mem_req_rdy, mem_resp_msg, mem_resp_val, proc_resp_rdy,
        input  proc_req_rdy, mem_req_msg, mem_req_val, mem_resp_rdy, proc_resp_msg, proc_resp_val
    );

    modport slave (
        input  proc_req_msg, proc_req_val, mem_req_rdy, mem_resp_msg, mem_resp_val, proc_resp_rdy,
        output proc_req_rdy, mem_req_msg, mem_req_val, mem_resp_rdy, proc_resp_msg, proc_resp_val
    );
endinterface

// File: rtl/mem_req_tracker.sv
// Counts in-flight memory requests and discards the responses of squashed ones.
// Optional MEM_REQ_TRACKER_STATS_EN adds a dropped-response counter and a stray-response check.
module mem_req_tracker #(
    parameter int p_req_nbits    = 77,
    parameter int p_resp_nbits   = 47,
    parameter int p_max_inflight = 4,
    localparam int c_cnt_nbits   = $clog2(p_max_inflight + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   squash,
    mem_req_tracker_if.slave       bus,
`ifdef MEM_REQ_TRACKER_STATS_EN
    output logic [15:0]            num_dropped,
`endif
    output logic [c_cnt_nbits-1:0] inflight
);
    localparam logic [c_cnt_nbits-1:0] MAX_CNT = c_cnt_nbits'(p_max_inflight);

    logic [c_cnt_nbits-1:0] inflight_q, inflight_d;
    logic [c_cnt_nbits-1:0] drop_cnt_q, drop_cnt_d;
    logic can_issue, req_go, resp_go, drop_now;

    // Credit check uses only the registered count: a response returning this
    // cycle does not free a slot until the next one.
    assign can_issue = (inflight_q < MAX_CNT) && !squash;
    assign drop_now  = (drop_cnt_q != '0) || squash;

    assign bus.mem_req_msg   = bus.proc_req_msg;
    assign bus.mem_req_val   = bus.proc_req_val && can_issue;
    assign bus.proc_req_rdy  = bus.mem_req_rdy && can_issue;
    assign bus.proc_resp_msg = bus.mem_resp_msg;
    assign bus.proc_resp_val = drop_now ? 1'b0 : bus.mem_resp_val;
    assign bus.mem_resp_rdy  = drop_now ? 1'b1 : bus.proc_resp_rdy;

    assign req_go  = bus.proc_req_val && bus.proc_req_rdy;
    assign resp_go = bus.mem_resp_val && bus.mem_resp_rdy;

    always_comb begin
        inflight_d = inflight_q;
        if (req_go && !resp_go)
            inflight_d = inflight_q + 1'b1;
        else if (!req_go && resp_go && inflight_q != '0)
            inflight_d = inflight_q - 1'b1;
    end

    // Squash re-marks everything still outstanding, so repeats never double count.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (squash)
            drop_cnt_d = (resp_go && inflight_q != '0) ? inflight_q - 1'b1 : inflight_q;
        else if (resp_go && drop_cnt_q != '0)
            drop_cnt_d = drop_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign inflight = inflight_q;

`ifdef MEM_REQ_TRACKER_STATS_EN
    logic [15:0] num_dropped_q;

    always_ff @(posedge clk) begin
        if (reset)
            num_dropped_q <= '0;
        else if (resp_go && drop_now && num_dropped_q != 16'hFFFF)
            num_dropped_q <= num_dropped_q + 16'd1;
    end

    assign num_dropped = num_dropped_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (reset || !resp_go || inflight_q != '0)
            else $error("mem_req_tracker: response accepted with nothing in flight");
    end
`endif
`endif
endmodule

// File: tb/tb_mem_req_tracker.sv
// Directed bench for mem_req_tracker: delivered responses are checked through a queue scoreboard.
module tb_mem_req_tracker;
    localparam int RQ = 77;
    localparam int RS = 47;

    logic       clk = 1'b0;
    logic       reset;
    logic       squash;
    logic [2:0] inflight;
`ifdef MEM_REQ_TRACKER_STATS_EN
    logic [15:0] num_dropped;
    int          exp_dropped = 0;
`endif

    int checks = 0;
    int errors = 0;
    logic [RS-1:0] sb[$];

    mem_req_tracker_if #(.p_req_nbits(RQ), .p_resp_nbits(RS)) b ();

    mem_req_tracker #(.p_req_nbits(RQ), .p_resp_nbits(RS), .p_max_inflight(4)) dut (
        .clk(clk),
        .reset(reset),
        .squash(squash),
        .bus(b.slave),
`ifdef MEM_REQ_TRACKER_STATS_EN
        .num_dropped(num_dropped),
`endif
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every delivered response must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && b.proc_resp_val === 1'b1 && b.proc_resp_rdy === 1'b1) begin
            if (sb.size() == 0) chk("resp_unexpected", 128'(b.proc_resp_msg), 128'hx);
            else chk("resp_msg", 128'(b.proc_resp_msg), 128'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [RQ-1:0] rmsg(input int n);
        return {13'h0, 32'($urandom), 32'(n)};
    endfunction

    task automatic issue(input int n, input int exp_inf);
        logic [RQ-1:0] m;
        m = rmsg(n);
        b.proc_req_val = 1'b1;
        b.proc_req_msg = m;
        #1;
        chk("req_rdy", 128'(b.proc_req_rdy), 128'(1));
        chk("req_val", 128'(b.mem_req_val), 128'(1));
        chk("req_msg", 128'(b.mem_req_msg), 128'(m));
        tick();
        b.proc_req_val = 1'b0;
        chk("inflight_issue", 128'(inflight), 128'(exp_inf));
    endtask

    task automatic resp(input int n, input bit dropped, input int exp_inf);
        b.mem_resp_val = 1'b1;
        b.mem_resp_msg = RS'(n * 97 + 5);
        if (!dropped) sb.push_back(RS'(n * 97 + 5));
`ifdef MEM_REQ_TRACKER_STATS_EN
        else exp_dropped++;
`endif
        #1;
        chk("resp_val", 128'(b.proc_resp_val), 128'(!dropped));
        chk("resp_rdy", 128'(b.mem_resp_rdy), 128'(1));
        tick();
        b.mem_resp_val = 1'b0;
        chk("inflight_resp", 128'(inflight), 128'(exp_inf));
    endtask

    initial begin
        reset = 1'b1;
        squash = 1'b0;
        b.proc_req_val = 1'b0;
        b.proc_req_msg = '0;
        b.mem_req_rdy = 1'b1;
        b.mem_resp_val = 1'b0;
        b.mem_resp_msg = '0;
        b.proc_resp_rdy = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_inflight", 128'(inflight), 128'(0));
        chk("reset_req_rdy", 128'(b.proc_req_rdy), 128'(1));
        chk("reset_resp_rdy", 128'(b.mem_resp_rdy), 128'(1));

        // Three requests, responses two cycles later, in order.
        issue(1, 1); issue(2, 2); issue(3, 3);
        tick();
        resp(1, 0, 2); resp(2, 0, 1); resp(3, 0, 0);

        // Fill to the limit, response cannot lend its credit in the same cycle.
        issue(4, 1); issue(5, 2); issue(6, 3); issue(7, 4);
        b.proc_req_val = 1'b1;
        #1;
        chk("full_req_rdy", 128'(b.proc_req_rdy), 128'(0));
        chk("full_req_val", 128'(b.mem_req_val), 128'(0));
        resp(4, 0, 3);
        b.proc_req_val = 1'b1;
        b.mem_resp_val = 1'b1;
        b.mem_resp_msg = RS'(5 * 97 + 5);
        sb.push_back(RS'(5 * 97 + 5));
        #1;
        chk("resume_req_rdy", 128'(b.proc_req_rdy), 128'(1));
        tick();
        b.proc_req_val = 1'b0;
        b.mem_resp_val = 1'b0;
        chk("same_cycle_inflight", 128'(inflight), 128'(3));
        resp(6, 0, 2); resp(7, 0, 1); resp(8, 0, 0);

        // Squash three outstanding; all three responses are swallowed.
        issue(9, 1); issue(10, 2); issue(11, 3);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        chk("squash_inflight", 128'(inflight), 128'(3));
        b.proc_resp_rdy = 1'b0;
        resp(9, 1, 2); resp(10, 1, 1); resp(11, 1, 0);
        issue(12, 1);
        b.mem_resp_val = 1'b1;
        b.mem_resp_msg = RS'(12 * 97 + 5);
        #1;
        chk("stall_resp_val", 128'(b.proc_resp_val), 128'(1));
        chk("stall_resp_rdy", 128'(b.mem_resp_rdy), 128'(0));
        tick();
        b.mem_resp_val = 1'b0;
        b.proc_resp_rdy = 1'b1;
        resp(12, 0, 0);

        // Squash coinciding with a response and a request.
        issue(13, 1); issue(14, 2);
        squash = 1'b1;
        b.proc_req_val = 1'b1;
        b.mem_resp_val = 1'b1;
        b.mem_resp_msg = RS'(13 * 97 + 5);
`ifdef MEM_REQ_TRACKER_STATS_EN
        exp_dropped++;
`endif
        #1;
        chk("sq_req_rdy", 128'(b.proc_req_rdy), 128'(0));
        chk("sq_req_val", 128'(b.mem_req_val), 128'(0));
        chk("sq_resp_val", 128'(b.proc_resp_val), 128'(0));
        chk("sq_resp_rdy", 128'(b.mem_resp_rdy), 128'(1));
        tick();
        squash = 1'b0;
        b.proc_req_val = 1'b0;
        b.mem_resp_val = 1'b0;
        chk("sq_resp_inflight", 128'(inflight), 128'(1));
        resp(14, 1, 0);
        issue(15, 1);
        resp(15, 0, 0);

        // Squash with nothing outstanding is harmless.
        squash = 1'b1;
        tick();
        squash = 1'b0;
        chk("idle_squash_inflight", 128'(inflight), 128'(0));
        issue(16, 1);
        resp(16, 0, 0);

        // Reset with two outstanding, one of them marked for dropping.
        issue(17, 1); issue(18, 2);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        resp(17, 1, 1);
        issue(19, 2);
`ifdef MEM_REQ_TRACKER_STATS_EN
        chk("num_dropped", 128'(num_dropped), 128'(exp_dropped));
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_inflight", 128'(inflight), 128'(0));
`ifdef MEM_REQ_TRACKER_STATS_EN
        chk("rst_num_dropped", 128'(num_dropped), 128'(0));
`endif
        b.mem_req_rdy = 1'b0;
        b.proc_req_val = 1'b1;
        #1;
        chk("rst_req_rdy", 128'(b.proc_req_rdy), 128'(0));
        chk("rst_req_val", 128'(b.mem_req_val), 128'(1));
        b.mem_req_rdy = 1'b1;
        b.proc_req_val = 1'b0;
        issue(20, 1);
        resp(20, 0, 0);

`ifndef MEM_REQ_TRACKER_STATS_EN
        // Stray response with nothing in flight: count must not wrap.
        resp(21, 0, 0);
        issue(22, 1);
        resp(22, 0, 0);
`endif
        tick();
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
